lcd_pattern_gen: RTL and testbench



---
 rtl/lcd_pattern_gen.sv | 217 +++++++++++++++++++++
 tb/tb_lcd_pattern_gen.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: two-stage test-pattern generator placed behind the LCD timing
// generator. Stage 1 registers timing and the selected pattern colour, stage 2
// registers the blanked RGB and the re-timed syncs, so every output lags its
// input by exactly two PIXEL_CLK cycles.
// Optional feature: define LCD_PATTERN_BORDER_EN to force a one-pixel white
// border around the active area in every mode.
module lcd_pattern_gen #(
  parameter int unsigned H_DISPLAY = 480,
  parameter int unsigned V_DISPLAY = 272,
  parameter int unsigned TILE_LOG2 = 4
) (
  input  logic        PIXEL_CLK,
  input  logic        RESET,
  input  logic        HSYNC_IN,
  input  logic        VSYNC_IN,
  input  logic        DEN_IN,
  input  logic [10:0] XPOS,
  input  logic [10:0] YPOS,
  input  logic [2:0]  MODE,
  input  logic [23:0] COLOR,
  output logic        LCD_HSYNC,
  output logic        LCD_VSYNC,
  output logic        LCD_DEN,
  output logic [7:0]  LCD_R,
  output logic [7:0]  LCD_G,
  output logic [7:0]  LCD_B,
  output logic [7:0]  FRAME_COUNT
);

  localparam int unsigned POS_W     = 11;
  localparam int unsigned RGB_W     = 24;
  localparam int unsigned CH_W      = 8;
  localparam int unsigned MODE_W    = 3;
  localparam int unsigned FC_W      = 8;
  localparam int unsigned BAR_IDX_W = 3;
  localparam int unsigned CNT_W     = POS_W;
  localparam int unsigned BAR_W     = H_DISPLAY / 8;

  localparam logic [RGB_W-1:0]     WHITE    = 24'hFFFFFF;
  localparam logic [RGB_W-1:0]     BLACK    = 24'h000000;
  localparam logic [BAR_IDX_W-1:0] BAR_LAST = 3'd7;
  localparam logic [CNT_W-1:0]     BAR_END  = CNT_W'(BAR_W - 1);

  // Colour of each vertical bar, left to right
  function automatic logic [RGB_W-1:0] bar_color(input logic [BAR_IDX_W-1:0] idx);
    logic [RGB_W-1:0] c;
    c = BLACK;
    case (idx)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  // Stage 1 registers
  logic               hs1_q, vs1_q, den1_q;
  logic [RGB_W-1:0]   rgb1_q;
  // Stage 2 (output) registers
  logic               hs2_q, vs2_q, den2_q;
  logic [RGB_W-1:0]   rgb2_q, rgb2_d;
  // Frame-latched control
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [RGB_W-1:0]   color_q, color_d;
  logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
  // Bar tracker
  logic [BAR_IDX_W-1:0] bar_q, bar_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 frame_start_c;
  logic                 den_rise_c;
  logic [BAR_IDX_W-1:0] bar_cur_c;
  logic [CNT_W-1:0]     cnt_cur_c;
  logic [POS_W-1:0]     scroll_x_c;
  logic                 checker_c;
  logic                 scroll_checker_c;
  logic [RGB_W-1:0]     pix_c;
  logic                 unused_c;

  // Event detection against the stage-1 copies of the timing inputs
  assign frame_start_c = ~VSYNC_IN & vs1_q;
  assign den_rise_c    = DEN_IN & ~den1_q;

  // Bar index/count seen by the current pixel; a new line restarts at bar 0
  assign bar_cur_c = den_rise_c ? '0 : bar_q;
  assign cnt_cur_c = den_rise_c ? '0 : cnt_q;

  // Checkerboard parity, static and scrolled by the frame counter
  assign scroll_x_c       = XPOS + POS_W'(frame_cnt_q);
  assign checker_c        = XPOS[TILE_LOG2] ^ YPOS[TILE_LOG2];
  assign scroll_checker_c = scroll_x_c[TILE_LOG2] ^ YPOS[TILE_LOG2];

  // Row bits outside the tile select are only consumed by the border logic
  assign unused_c = ^{YPOS, POS_W'(V_DISPLAY - 1)};

`ifdef LCD_PATTERN_BORDER_EN
  logic on_border_c;

  // Outermost row/column of the active area
  assign on_border_c = (XPOS == POS_W'(0)) || (XPOS == POS_W'(H_DISPLAY - 1)) ||
                       (YPOS == POS_W'(0)) || (YPOS == POS_W'(V_DISPLAY - 1));
`endif

  // Bar tracker next state: advance one bar every BAR_W pixels, bar 7 takes the rest
  always_comb begin
    bar_d = bar_q;
    cnt_d = cnt_q;
    if (DEN_IN) begin
      if ((cnt_cur_c == BAR_END) && (bar_cur_c != BAR_LAST)) begin
        bar_d = bar_cur_c + BAR_IDX_W'(1);
        cnt_d = '0;
      end else begin
        bar_d = bar_cur_c;
        cnt_d = cnt_cur_c + CNT_W'(1);
      end
    end
  end

  // Mode/colour latch and frame counter, updated only on a frame start
  always_comb begin
    mode_d      = mode_q;
    color_d     = color_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_start_c) begin
      mode_d      = MODE;
      color_d     = COLOR;
      frame_cnt_d = frame_cnt_q + FC_W'(1);
    end
  end

  // Pattern colour for the current pixel, always from the mode latched before this edge
  always_comb begin
    pix_c = BLACK;
    case (mode_q)
      3'd0:    pix_c = color_q;
      3'd1:    pix_c = bar_color(bar_cur_c);
      3'd2:    pix_c = checker_c ? WHITE : BLACK;
      3'd3:    pix_c = {3{XPOS[CH_W-1:0]}};
      3'd4:    pix_c = scroll_checker_c ? WHITE : BLACK;
      default: pix_c = BLACK;
    endcase
`ifdef LCD_PATTERN_BORDER_EN
    if (on_border_c) begin
      pix_c = WHITE;
    end
`endif
  end

  // Stage-2 blanking outside the active area
  always_comb begin
    rgb2_d = BLACK;
    if (den1_q) begin
      rgb2_d = rgb1_q;
    end
  end

  // Control registers: latched mode/colour, frame counter, bar tracker
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      mode_q      <= '0;
      color_q     <= '0;
      frame_cnt_q <= '0;
      bar_q       <= '0;
      cnt_q       <= '0;
    end else begin
      mode_q      <= mode_d;
      color_q     <= color_d;
      frame_cnt_q <= frame_cnt_d;
      bar_q       <= bar_d;
      cnt_q       <= cnt_d;
    end
  end

  // Stage 1: capture timing and the selected pattern colour
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      den1_q <= 1'b0;
      rgb1_q <= '0;
    end else begin
      hs1_q  <= HSYNC_IN;
      vs1_q  <= VSYNC_IN;
      den1_q <= DEN_IN;
      rgb1_q <= pix_c;
    end
  end

  // Stage 2: final RGB and syncs, aligned with each other
  always_ff @(posedge PIXEL_CLK) begin
    if (RESET) begin
      hs2_q  <= 1'b1;
      vs2_q  <= 1'b1;
      den2_q <= 1'b0;
      rgb2_q <= '0;
    end else begin
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      den2_q <= den1_q;
      rgb2_q <= rgb2_d;
    end
  end

  assign LCD_HSYNC   = hs2_q;
  assign LCD_VSYNC   = vs2_q;
  assign LCD_DEN     = den2_q;
  assign LCD_R       = rgb2_q[23:16];
  assign LCD_G       = rgb2_q[15:8];
  assign LCD_B       = rgb2_q[7:0];
  assign FRAME_COUNT = frame_cnt_q;

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Testbench for lcd_pattern_gen: drives abbreviated frames, pushes the
// expected {hsync, vsync, den, rgb} for every driven cycle into a queue and
// compares it two clocks later when the DUT presents that pixel.
module tb_lcd_pattern_gen;

  localparam int H_LAST = 479;
  localparam int V_LAST = 271;
  localparam int BAR_PIX = 60;
  localparam logic [26:0] IDLE = {1'b1, 1'b1, 1'b0, 24'h000000};

  logic        clk;
  logic        RESET;
  logic        HSYNC_IN, VSYNC_IN, DEN_IN;
  logic [10:0] XPOS, YPOS;
  logic [2:0]  MODE;
  logic [23:0] COLOR;
  logic        LCD_HSYNC, LCD_VSYNC, LCD_DEN;
  logic [7:0]  LCD_R, LCD_G, LCD_B;
  logic [7:0]  FRAME_COUNT;

  typedef struct {
    logic [26:0] v;
    int          due;
    int          x;
    int          y;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [2:0]  m_mode;
  logic [23:0] m_col;
  logic [7:0]  m_fc;
  logic        m_vs_prev;
  logic        m_den_prev;
  int          m_pix;

  // Requested (not yet latched) mode/colour driven onto MODE/COLOR
  logic [2:0]  mode_r;
  logic [23:0] color_r;

  lcd_pattern_gen dut (
    .PIXEL_CLK   (clk),
    .RESET       (RESET),
    .HSYNC_IN    (HSYNC_IN),
    .VSYNC_IN    (VSYNC_IN),
    .DEN_IN      (DEN_IN),
    .XPOS        (XPOS),
    .YPOS        (YPOS),
    .MODE        (MODE),
    .COLOR       (COLOR),
    .LCD_HSYNC   (LCD_HSYNC),
    .LCD_VSYNC   (LCD_VSYNC),
    .LCD_DEN     (LCD_DEN),
    .LCD_R       (LCD_R),
    .LCD_G       (LCD_G),
    .LCD_B       (LCD_B),
    .FRAME_COUNT (FRAME_COUNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: compare each pixel when it reaches the outputs
  always @(posedge clk) begin : monitor
    exp_t        e;
    logic [26:0] obs;
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e   = q.pop_front();
      obs = {LCD_HSYNC, LCD_VSYNC, LCD_DEN, LCD_R, LCD_G, LCD_B};
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL pixel x=%0d y=%0d cyc=%0d: got hs/vs/den/rgb=%b/%b/%b/%h expected %b/%b/%b/%h",
                 e.x, e.y, cyc, obs[26], obs[25], obs[24], obs[23:0],
                 e.v[26], e.v[25], e.v[24], e.v[23:0]);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no $finish, expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [23:0] bar_ref(input int b);
    logic [23:0] c;
    case (b)
      0:       c = 24'hFFFFFF;
      1:       c = 24'hFFFF00;
      2:       c = 24'h00FFFF;
      3:       c = 24'h00FF00;
      4:       c = 24'hFF00FF;
      5:       c = 24'hFF0000;
      6:       c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  function automatic logic [23:0] exp_pix(input logic [2:0] md, input logic [23:0] col,
                                          input logic [7:0] fc, input int x, input int y,
                                          input int pix);
    logic [23:0] p;
    logic [10:0] xv, yv, xs;
    logic [7:0]  g;
    int          b;
    xv = 11'(x);
    yv = 11'(y);
    g  = xv[7:0];
    xs = xv + {3'b000, fc};
    b  = pix / BAR_PIX;
    if (b > 7) b = 7;
    case (md)
      3'd0:    p = col;
      3'd1:    p = bar_ref(b);
      3'd2:    p = (xv[4] ^ yv[4]) ? 24'hFFFFFF : 24'h000000;
      3'd3:    p = {g, g, g};
      3'd4:    p = (xs[4] ^ yv[4]) ? 24'hFFFFFF : 24'h000000;
      default: p = 24'h000000;
    endcase
`ifdef LCD_PATTERN_BORDER_EN
    if (x == 0 || x == H_LAST || y == 0 || y == V_LAST) p = 24'hFFFFFF;
`endif
    return p;
  endfunction

  // Drive one cycle of inputs and push what the outputs must show two clocks later
  task automatic step(input logic rst, input logic hs, input logic vs, input logic den,
                      input int x, input int y);
    exp_t        e;
    exp_t        prev;
    logic [23:0] rgb;
    @(negedge clk);
    RESET    = rst;
    HSYNC_IN = hs;
    VSYNC_IN = vs;
    DEN_IN   = den;
    XPOS     = den ? 11'(x) : 11'd0;
    YPOS     = den ? 11'(y) : 11'd0;
    MODE     = mode_r;
    COLOR    = color_r;
    e.due = cyc + 2;
    e.x   = x;
    e.y   = y;
    if (rst) begin
      // The reset edge also wipes the pixel already in flight
      if (q.size() > 0) begin
        prev   = q.pop_back();
        prev.v = IDLE;
        q.push_back(prev);
      end
      e.v        = IDLE;
      m_mode     = 3'd0;
      m_col      = 24'h000000;
      m_fc       = 8'd0;
      m_vs_prev  = 1'b1;
      m_den_prev = 1'b0;
      m_pix      = 0;
    end else begin
      if (den && !m_den_prev) m_pix = 0;
      rgb = den ? exp_pix(m_mode, m_col, m_fc, x, y, m_pix) : 24'h000000;
      e.v = {hs, vs, den, rgb};
      if (den) m_pix++;
      if (!vs && m_vs_prev) begin
        m_mode = mode_r;
        m_col  = color_r;
        m_fc   = m_fc + 8'd1;
      end
      m_vs_prev  = vs;
      m_den_prev = den;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic vblank();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic do_line(input int y, input int n);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b1, 1'b1, i, y);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_reset();
    mode_r  = 3'd0;
    color_r = 24'h123456;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    idle(2);
    checks++;
    if ({LCD_HSYNC, LCD_VSYNC, LCD_DEN, LCD_R, LCD_G, LCD_B, FRAME_COUNT} !== {IDLE, 8'd0}) begin
      errors++;
      $display("FAIL reset_idle: got hs/vs/den/rgb/fc=%b/%b/%b/%h%h%h/%0d expected 1/1/0/000000/0",
               LCD_HSYNC, LCD_VSYNC, LCD_DEN, LCD_R, LCD_G, LCD_B, FRAME_COUNT);
    end
    // Start a coloured frame, then reset in the middle of an active line
    vblank();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 1'b1, i, 0);
    for (int i = 10; i < 13; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, i, 0);
      @(posedge clk);
      #1;
      checks++;
      if ({LCD_HSYNC, LCD_VSYNC, LCD_DEN, LCD_R, LCD_G, LCD_B, FRAME_COUNT} !== {IDLE, 8'd0}) begin
        errors++;
        $display("FAIL reset_midline x=%0d: got hs/vs/den/rgb/fc=%b/%b/%b/%h%h%h/%0d expected 1/1/0/000000/0",
                 i, LCD_HSYNC, LCD_VSYNC, LCD_DEN, LCD_R, LCD_G, LCD_B, FRAME_COUNT);
      end
    end
    // Rest of the interrupted frame stays black
    for (int i = 13; i < 40; i++) step(1'b0, 1'b1, 1'b1, 1'b1, i, 0);
    idle(2);
    checks++;
    if (FRAME_COUNT !== 8'd0) begin
      errors++;
      $display("FAIL reset_fc_hold: got %0d expected 0", FRAME_COUNT);
    end
    vblank();
    checks++;
    if (FRAME_COUNT !== 8'd1) begin
      errors++;
      $display("FAIL reset_first_frame_fc: got %0d expected 1", FRAME_COUNT);
    end
    do_line(0, 16);
  endtask

  task automatic test_solid();
    mode_r  = 3'd0;
    color_r = 24'h123456;
    vblank();
    do_line(0, 16);
    // Mid-frame request must wait for the next frame start
    mode_r  = 3'd2;
    color_r = 24'h654321;
    do_line(1, 16);
    do_line(16, 32);
    vblank();
    do_line(16, 32);
  endtask

  task automatic test_bars();
    mode_r = 3'd1;
    vblank();
    do_line(0, 480);
    do_line(1, 480);
  endtask

  task automatic test_checker();
    mode_r = 3'd2;
    vblank();
    do_line(0, 32);
    do_line(16, 32);
  endtask

  task automatic test_gray();
    mode_r = 3'd3;
    vblank();
    do_line(5, 300);
  endtask

  task automatic test_back_to_back();
    logic [7:0] fc_before;
    fc_before = FRAME_COUNT;
    mode_r  = 3'd0;
    color_r = 24'hABCDEF;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 0, 3);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 3);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b1, i, 3);
    // Frame start coincides with an active pixel
    for (int i = 5; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b1, i, 3);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    checks++;
    if (FRAME_COUNT !== fc_before + 8'd1) begin
      errors++;
      $display("FAIL b2b_fc: got %0d expected %0d", FRAME_COUNT, fc_before + 8'd1);
    end
    do_line(4, 8);
  endtask

  task automatic test_border();
    mode_r = 3'd5;
    vblank();
    do_line(0, 480);
    do_line(135, 480);
    do_line(271, 480);
  endtask

  task automatic test_scroll();
    mode_r = 3'd4;
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    idle(1);
    for (int f = 1; f <= 257; f++) begin
      vblank();
      checks++;
      if (FRAME_COUNT !== 8'(f)) begin
        errors++;
        $display("FAIL scroll_fc frame=%0d: got %0d expected %0d", f, FRAME_COUNT, 8'(f));
      end
      do_line(0, 32);
    end
    checks++;
    if (FRAME_COUNT !== 8'd1) begin
      errors++;
      $display("FAIL scroll_wrap: got %0d expected 1", FRAME_COUNT);
    end
  endtask

  initial begin
    RESET    = 1'b1;
    HSYNC_IN = 1'b1;
    VSYNC_IN = 1'b1;
    DEN_IN   = 1'b0;
    XPOS     = 11'd0;
    YPOS     = 11'd0;
    MODE     = 3'd0;
    COLOR    = 24'h000000;
    mode_r   = 3'd0;
    color_r  = 24'h000000;
    m_mode   = 3'd0;
    m_col    = 24'h000000;
    m_fc     = 8'd0;
    m_vs_prev  = 1'b1;
    m_den_prev = 1'b0;
    m_pix    = 0;

    test_reset();
    test_solid();
    test_bars();
    test_checker();
    test_gray();
    test_back_to_back();
    test_border();
    test_scroll();
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
